// File: rtl/energy_pkg.sv
// Shared definitions for the energy-detector digitizer capture engine:
// sample widths, capture FSM encoding and window-configuration clamping.
package energy_pkg;

  localparam int ADCW = 14;
  localparam int DW   = ADCW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POST = 2'd1,
    ST_READ = 2'd2
  } cap_state_e;

  // An unusable window length falls back to the whole ring.
  function automatic int unsigned clamp_nsamp(input int unsigned nsamp, input int unsigned depth);
    if ((nsamp == 32'd0) || (nsamp > depth)) begin
      return depth;
    end else begin
      return nsamp;
    end
  endfunction

  function automatic int unsigned clamp_pre(input int unsigned pre, input int unsigned nsamp);
    if (pre > nsamp) begin
      return nsamp;
    end else begin
      return pre;
    end
  endfunction

endpackage

// File: rtl/digi_ring_buffer.sv
// Simple dual-port ring storage: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module digi_ring_buffer
  import energy_pkg::*;
#(
  parameter int W     = 3 * DW,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; output holds between reads
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/energy_digi_capture.sv
// N-channel ADC capture engine: pre-trigger ring, threshold requests, windowed
// readout over valid/ready. Optional PEDESTAL_SUB_EN adds per-channel pedestal subtraction.
module energy_digi_capture
  import energy_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int DEPTH = 64,
  parameter int DROPW = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = (NCH > 4) ? $clog2(NCH) : 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [NCH*DW-1:0] Sample,
  input  logic [ADCW-1:0]   CfgThresh,
  input  logic [AW:0]       CfgNSamp,
  input  logic [AW:0]       CfgPre,
`ifdef PEDESTAL_SUB_EN
  input  logic [NCH*ADCW-1:0] CfgPed,
`endif
  input  logic              TrgIn,
  output logic [NCH-1:0]    TReqOut,
  output logic [DW-1:0]     DoutData,
  output logic [CW-1:0]     DoutChan,
  output logic              DoutLast,
  output logic              DoutVld,
  input  logic              DoutRdy,
  output logic              Busy,
  output logic [DROPW-1:0]  DropCnt
);

  localparam logic [AW:0]    CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]  PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CH_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CH_LAST = CW'(NCH - 1);
  localparam logic [DROPW-1:0] DROP_ONE = {{(DROPW-1){1'b0}}, 1'b1};

  cap_state_e state_r, state_s;
  logic accept_s, wr_en_s, in_read_s;
  logic load_s, rd_req_s, last_ch_s, xfer_last_s;
  logic [AW:0] nsamp_cl_s, pre_cl_s, post_len_s;
  logic [AW:0] nsamp_r, post_cnt_r, rd_cnt_r;
  logic [AW-1:0] wptr_r, rd_addr_s;
  logic [CW-1:0] ch_r;
  logic row_vld_r, last_row_r;
  logic [NCH*DW-1:0] proc_s, rd_data_s;

`ifdef PEDESTAL_SUB_EN
  logic [NCH*DW-1:0] proc_r;

  // Pedestal subtraction stage: magnitude floored at zero, OTR passes through
  always_ff @(posedge CLK) begin
    if (Reset) begin
      proc_r <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (Sample[c*DW +: ADCW] > CfgPed[c*ADCW +: ADCW]) begin
          proc_r[c*DW +: ADCW] <= Sample[c*DW +: ADCW] - CfgPed[c*ADCW +: ADCW];
        end else begin
          proc_r[c*DW +: ADCW] <= {ADCW{1'b0}};
        end
        proc_r[c*DW+ADCW] <= Sample[c*DW+ADCW];
      end
    end
  end
  assign proc_s = proc_r;
`else
  assign proc_s = Sample;
`endif

  // Per-channel trigger request, live in every state
  always_ff @(posedge CLK) begin
    if (Reset) begin
      TReqOut <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        TReqOut[c] <= (proc_s[c*DW +: ADCW] > CfgThresh) | proc_s[c*DW+ADCW];
      end
    end
  end

  assign nsamp_cl_s = (AW+1)'(clamp_nsamp(32'(CfgNSamp), 32'(DEPTH)));
  assign pre_cl_s   = (AW+1)'(clamp_pre(32'(CfgPre), 32'(nsamp_cl_s)));
  assign post_len_s = nsamp_cl_s - pre_cl_s;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; a post length of 0 or 1 is complete once the trigger sample is written
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (TrgIn) begin
          if (post_len_s <= CNT_ONE) state_s = ST_READ;
          else                       state_s = ST_POST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_POST: begin
        if (post_cnt_r == CNT_ONE) state_s = ST_READ;
        else                       state_s = ST_POST;
      end
      ST_READ: begin
        if (xfer_last_s) state_s = ST_IDLE;
        else             state_s = ST_READ;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM decoded controls
  always_comb begin
    accept_s  = 1'b0;
    wr_en_s   = 1'b0;
    in_read_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = TrgIn;
        wr_en_s  = 1'b1;
      end
      ST_POST: wr_en_s   = 1'b1;
      ST_READ: in_read_s = 1'b1;
      default: begin
        accept_s  = 1'b0;
        wr_en_s   = 1'b0;
        in_read_s = 1'b0;
      end
    endcase
  end

  // Window config latch and post-trigger write countdown
  always_ff @(posedge CLK) begin
    if (Reset) begin
      nsamp_r    <= '0;
      post_cnt_r <= '0;
    end else if (accept_s) begin
      nsamp_r    <= nsamp_cl_s;
      post_cnt_r <= post_len_s - CNT_ONE;
    end else if (state_r == ST_POST) begin
      post_cnt_r <= post_cnt_r - CNT_ONE;
    end else begin
      post_cnt_r <= post_cnt_r;
    end
  end

  // Write pointer, frozen during readout
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wptr_r <= '0;
    end else if (wr_en_s) begin
      wptr_r <= wptr_r + PTR_ONE;
    end else begin
      wptr_r <= wptr_r;
    end
  end

  assign last_ch_s   = (ch_r == CH_LAST);
  assign load_s      = in_read_s & row_vld_r & (~DoutVld | DoutRdy);
  assign rd_req_s    = in_read_s & (rd_cnt_r != nsamp_r) & (~row_vld_r | (load_s & last_ch_s));
  assign xfer_last_s = in_read_s & DoutVld & DoutRdy & DoutLast;
  assign rd_addr_s   = wptr_r - nsamp_r[AW-1:0] + rd_cnt_r[AW-1:0];

  // Row fetch: next row is requested as the last channel of the current row leaves
  always_ff @(posedge CLK) begin
    if (Reset || !in_read_s) begin
      rd_cnt_r   <= '0;
      row_vld_r  <= 1'b0;
      last_row_r <= 1'b0;
      ch_r       <= '0;
    end else begin
      if (rd_req_s) begin
        rd_cnt_r   <= rd_cnt_r + CNT_ONE;
        row_vld_r  <= 1'b1;
        last_row_r <= (rd_cnt_r == (nsamp_r - CNT_ONE));
      end else if (load_s && last_ch_s) begin
        row_vld_r  <= 1'b0;
      end
      if (load_s) begin
        ch_r <= last_ch_s ? {CW{1'b0}} : ch_r + CH_ONE;
      end
    end
  end

  // Output register: holds while stalled, Busy tracks the FSM
  always_ff @(posedge CLK) begin
    if (Reset) begin
      DoutVld  <= 1'b0;
      DoutData <= '0;
      DoutChan <= '0;
      DoutLast <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      if (load_s) begin
        DoutVld  <= 1'b1;
        DoutData <= rd_data_s[ch_r*DW +: DW];
        DoutChan <= ch_r;
        DoutLast <= last_row_r & last_ch_s;
      end else if (DoutRdy || !in_read_s) begin
        DoutVld  <= 1'b0;
        DoutLast <= 1'b0;
      end
      Busy <= (state_s != ST_IDLE);
    end
  end

  // Saturating count of triggers arriving while busy
  always_ff @(posedge CLK) begin
    if (Reset) begin
      DropCnt <= '0;
    end else if (TrgIn && (state_r != ST_IDLE) && (DropCnt != {DROPW{1'b1}})) begin
      DropCnt <= DropCnt + DROP_ONE;
    end else begin
      DropCnt <= DropCnt;
    end
  end

  digi_ring_buffer #(
    .W     (NCH*DW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (CLK),
    .wr_en   (wr_en_s),
    .wr_addr (wptr_r),
    .wr_data (proc_s),
    .rd_en   (rd_req_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

endmodule

// File: tb/tb_energy_digi_capture.sv
// Directed bench for energy_digi_capture: ramp windows, backpressure, drops,
// threshold requests, clamping and mid-readout reset.
module tb_energy_digi_capture;
  import energy_pkg::*;

  localparam int NCH = 3;
  localparam int DEPTH = 64;
  localparam int DROPW = 8;
  localparam int AW = 6;
  localparam int CW = 2;
`ifdef PEDESTAL_SUB_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic CLK = 1'b0;
  logic Reset, TrgIn, DoutRdy;
  logic [NCH*DW-1:0] Sample;
  logic [ADCW-1:0] CfgThresh;
  logic [AW:0] CfgNSamp, CfgPre;
`ifdef PEDESTAL_SUB_EN
  logic [NCH*ADCW-1:0] CfgPed;
`endif
  logic [NCH-1:0] TReqOut;
  logic [DW-1:0] DoutData;
  logic [CW-1:0] DoutChan;
  logic DoutLast, DoutVld, Busy;
  logic [DROPW-1:0] DropCnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit ramp_on = 1'b0;
  int t_trg;

  energy_digi_capture #(.NCH(NCH), .DEPTH(DEPTH), .DROPW(DROPW)) dut (
    .CLK(CLK), .Reset(Reset), .Sample(Sample), .CfgThresh(CfgThresh),
    .CfgNSamp(CfgNSamp), .CfgPre(CfgPre),
`ifdef PEDESTAL_SUB_EN
    .CfgPed(CfgPed),
`endif
    .TrgIn(TrgIn), .TReqOut(TReqOut), .DoutData(DoutData), .DoutChan(DoutChan),
    .DoutLast(DoutLast), .DoutVld(DoutVld), .DoutRdy(DoutRdy), .Busy(Busy), .DropCnt(DropCnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (ramp_on) begin
      for (int c = 0; c < NCH; c++) Sample[c*DW +: DW] = DW'(100*c + cyc);
    end
  endtask

  task automatic set_samp(input int s0, input int s1, input int s2);
    Sample = {DW'(s2), DW'(s1), DW'(s0)};
  endtask

  task automatic trig_at(input int at, output int t);
    while (cyc < at) tick();
    t = cyc;
    TrgIn = 1'b1;
    tick();
    TrgIn = 1'b0;
  endtask

  // Drain one window; word k carries sample k/NCH of channel k%NCH
  task automatic readout(input int base, input int nsamp, input bit toggle, input int ndrop,
                         input bit trg_last, input int first_cyc);
    int total;
    int k;
    int iter;
    int drops;
    bit held;
    bit phase;
    bit seen;
    logic [DW-1:0] h_data;
    logic [CW-1:0] h_chan;
    logic h_last;
    total = nsamp * NCH;
    k = 0; iter = 0; drops = 0; held = 1'b0; phase = 1'b0; seen = 1'b0;
    h_data = '0; h_chan = '0; h_last = 1'b0;
    while (k < total && iter < 3000) begin
      DoutRdy = toggle ? phase : 1'b1;
      phase = ~phase;
      TrgIn = 1'b0;
      if (drops < ndrop && (iter % 2) == 1) begin
        TrgIn = 1'b1;
        drops++;
      end
      if (held) begin
        check_val("hold_vld", 32'(DoutVld), 32'd1);
        check_val("hold_data", 32'(DoutData), 32'(h_data));
        check_val("hold_chan", 32'(DoutChan), 32'(h_chan));
        check_val("hold_last", 32'(DoutLast), 32'(h_last));
      end
      if (DoutVld) begin
        if (!seen && first_cyc >= 0) check_val("first_vld_cycle", 32'(cyc), 32'(first_cyc));
        seen = 1'b1;
        if (DoutRdy) begin
          check_val("word_data", 32'(DoutData), 32'(100*(k % NCH) + base + k / NCH));
          check_val("word_chan", 32'(DoutChan), 32'(k % NCH));
          check_val("word_last", 32'(DoutLast), 32'(k == total - 1));
          if (k == total - 1 && trg_last) TrgIn = 1'b1;
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          h_data = DoutData; h_chan = DoutChan; h_last = DoutLast;
        end
      end
      tick();
      iter++;
    end
    TrgIn = 1'b0;
    DoutRdy = 1'b1;
    check_val("window_words", 32'(k), 32'(total));
    check_val("busy_after_last", 32'(Busy), 32'd0);
    check_val("vld_after_last", 32'(DoutVld), 32'd0);
  endtask

  initial begin
    int k;
    int guard;
    Reset = 1'b1; TrgIn = 1'b0; DoutRdy = 1'b1; Sample = '0;
    CfgThresh = 14'h3FFF; CfgNSamp = 7'd8; CfgPre = 7'd3;
`ifdef PEDESTAL_SUB_EN
    CfgPed = '0;
`endif
    repeat (3) tick();
    check_val("rst_vld", 32'(DoutVld), 32'd0);
    check_val("rst_busy", 32'(Busy), 32'd0);
    check_val("rst_drop", 32'(DropCnt), 32'd0);
    check_val("rst_treq", 32'(TReqOut), 32'd0);
    check_val("rst_last", 32'(DoutLast), 32'd0);
    check_val("rst_data", 32'(DoutData), 32'd0);
    check_val("rst_chan", 32'(DoutChan), 32'd0);

    // Basic window with mid-window cfg change and three busy drops
    Reset = 1'b0; cyc = 0; ramp_on = 1'b1; set_samp(0, 100, 200);
    trig_at(50, t_trg);
    check_val("busy_after_trg", 32'(Busy), 32'd1);
    CfgNSamp = 7'd4; CfgPre = 7'd0;
    readout(47 - (LAT - 1), 8, 1'b0, 3, 1'b0, 57);
    CfgNSamp = 7'd8; CfgPre = 7'd3;
    check_val("drop_three", 32'(DropCnt), 32'd3);

    // Backpressure toggling, trigger on the DoutLast transfer is dropped
    trig_at(cyc + 5, t_trg);
    readout(t_trg - 3 - (LAT - 1), 8, 1'b1, 0, 1'b1, -1);
    check_val("drop_on_last", 32'(DropCnt), 32'd4);
    tick();
    check_val("no_restart_after_last", 32'(Busy), 32'd0);

    // NSamp=0 clamps to full ring depth
    CfgNSamp = 7'd0; CfgPre = 7'd3;
    trig_at(cyc + 5, t_trg);
    readout(t_trg - 3 - (LAT - 1), DEPTH, 1'b0, 0, 1'b0, -1);
    CfgNSamp = 7'd8; CfgPre = 7'd3;

    // Threshold compare: strictly greater, OTR forces request
    ramp_on = 1'b0; CfgThresh = 14'd1000;
    set_samp(0, 999, 0);
    repeat (LAT) tick();
    check_val("treq_999", 32'(TReqOut), 32'd0);
    set_samp(0, 1001, 0);
    repeat (LAT - 1) tick();
    check_val("treq_before_lat", 32'(TReqOut), 32'd0);
    tick();
    check_val("treq_1001", 32'(TReqOut), 32'b010);
    set_samp(0, 1000, 0);
    repeat (LAT) tick();
    check_val("treq_equal", 32'(TReqOut), 32'd0);
    set_samp(0, 0, 16384);
    repeat (LAT) tick();
    check_val("treq_otr", 32'(TReqOut), 32'b100);
`ifdef PEDESTAL_SUB_EN
    CfgPed = {3{14'd500}}; CfgThresh = 14'd99;
    set_samp(0, 0, 0);
    repeat (2) tick();
    set_samp(600, 400, 0);
    tick();
    check_val("ped_lat1", 32'(TReqOut), 32'd0);
    tick();
    check_val("ped_600_400", 32'(TReqOut), 32'b001);
    CfgThresh = 14'd100;
    tick();
    check_val("ped_mag_100", 32'(TReqOut), 32'd0);
    CfgPed = '0;
`endif
    CfgThresh = 14'h3FFF; ramp_on = 1'b1;
    tick();

    // Saturating drop count while stalled, then reset at word 10
    trig_at(cyc + 5, t_trg);
    DoutRdy = 1'b0; TrgIn = 1'b1;
    repeat (300) tick();
    TrgIn = 1'b0;
    check_val("drop_saturate", 32'(DropCnt), 32'd255);
    check_val("stall_vld", 32'(DoutVld), 32'd1);
    DoutRdy = 1'b1; k = 0; guard = 0;
    while (k < 10 && guard < 100) begin
      if (DoutVld) k++;
      tick();
      guard++;
    end
    check_val("words_before_reset", 32'(k), 32'd10);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_val("abort_vld", 32'(DoutVld), 32'd0);
    check_val("abort_busy", 32'(Busy), 32'd0);
    check_val("abort_last", 32'(DoutLast), 32'd0);
    check_val("abort_drop", 32'(DropCnt), 32'd0);
    trig_at(cyc + 10, t_trg);
    readout(t_trg - 3 - (LAT - 1), 8, 1'b0, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
